vram_portb_arbiter: RTL

VRAM_PORTB_ARBITER -- requirements
Module: vram_portb_arbiter

---
 rtl/gameconsole_pkg.sv | 27 ++
 rtl/vram_rsp_pipe.sv | 37 +++
 rtl/vram_portb_arbiter.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/gameconsole_pkg.sv
// Shared types and defaults for the game console video subsystem.
package gameconsole_pkg;

  localparam int TILE_ADDR_W    = 12;
  localparam int TILE_DATA_W    = 16;
  localparam int VRAM_RD_LAT    = 1;
  localparam int VRAM_MAX_BURST = 8;

  // Port B arbiter states.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BG_BURST = 2'd1,
    SP_BURST = 2'd2
  } arb_state_t;

  // Requester identity, also used as the response tag.
  typedef enum logic {
    REQ_BG = 1'b0,
    REQ_SP = 1'b1
  } req_id_t;

  function automatic req_id_t other_req(input req_id_t id);
    if (id == REQ_BG) return REQ_SP;
    return REQ_BG;
  endfunction

endpackage

// File: rtl/vram_rsp_pipe.sv
// Valid + owner tag delay line matching the VRAM read latency, so each
// read response is steered back to the engine that issued the beat.
module vram_rsp_pipe
  import gameconsole_pkg::*;
#(
  parameter int RD_LAT = VRAM_RD_LAT
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    issue,
  input  req_id_t owner,
  output logic    valid,
  output req_id_t valid_owner
);

  logic [RD_LAT-1:0] vld_sr;
  logic [RD_LAT-1:0] own_sr;

  // Shift issue/owner through RD_LAT stages; reset drops anything in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_sr <= '0;
      own_sr <= '0;
    end else begin
      vld_sr[0] <= issue;
      own_sr[0] <= owner;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_sr[i] <= vld_sr[i-1];
        own_sr[i] <= own_sr[i-1];
      end
    end
  end

  assign valid       = vld_sr[RD_LAT-1];
  assign valid_owner = req_id_t'(own_sr[RD_LAT-1]);

endmodule

// File: rtl/vram_portb_arbiter.sv
// Read-only VRAM port B arbiter between the background and sprite engines.
// Grants are combinational (beat 1 in the same cycle as the request), bursts
// are capped at MAX_BURST beats, and priority flips on every release so that
// a waiting engine always gets the next beat.
//
// state    | meaning
// IDLE     | no owner; pick a winner this cycle (prio breaks ties)
// BG_BURST | background engine owns the port, beats while bg_req=1
// SP_BURST | sprite engine owns the port, beats while sp_req=1
module vram_portb_arbiter
  import gameconsole_pkg::*;
#(
  parameter int ADDR_W    = TILE_ADDR_W,
  parameter int DATA_W    = TILE_DATA_W,
  parameter int RD_LAT    = VRAM_RD_LAT,
  parameter int MAX_BURST = VRAM_MAX_BURST
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bg_req,
  input  logic              bg_last,
  input  logic [ADDR_W-1:0] bg_addr,
  output logic              bg_gnt,
  output logic              bg_rvalid,
  output logic [DATA_W-1:0] bg_rdata,
  input  logic              sp_req,
  input  logic              sp_last,
  input  logic [ADDR_W-1:0] sp_addr,
  output logic              sp_gnt,
  output logic              sp_rvalid,
  output logic [DATA_W-1:0] sp_rdata,
  output logic              ram_en,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_dout
);

  localparam int              CNT_W   = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  arb_state_t       state, state_nxt;
  req_id_t          prio, prio_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  logic    beat;
  logic    beat_ok;
  req_id_t beat_owner;
  logic    beat_last;
  logic    rsp_valid;
  req_id_t rsp_owner;

  // Choose who beats this cycle and where the FSM goes next.
  always_comb begin
    state_nxt  = state;
    prio_nxt   = prio;
    cnt_nxt    = cnt;
    beat       = 1'b0;
    beat_owner = REQ_BG;
    beat_last  = 1'b0;

    case (state)
      IDLE: begin
        if (bg_req && (!sp_req || prio == REQ_BG)) begin
          beat       = 1'b1;
          beat_owner = REQ_BG;
          beat_last  = bg_last;
        end else if (sp_req) begin
          beat       = 1'b1;
          beat_owner = REQ_SP;
          beat_last  = sp_last;
        end
        if (beat) begin
          if (beat_last) begin
            // Single-beat grant: stay idle but hand priority over.
            prio_nxt = other_req(beat_owner);
            cnt_nxt  = '0;
          end else begin
            if (beat_owner == REQ_BG) state_nxt = BG_BURST;
            else                      state_nxt = SP_BURST;
            cnt_nxt = CNT_ONE;
          end
        end
      end

      BG_BURST, SP_BURST: begin
        if (state == BG_BURST) begin
          beat_owner = REQ_BG;
          beat       = bg_req;
          beat_last  = bg_last;
        end else begin
          beat_owner = REQ_SP;
          beat       = sp_req;
          beat_last  = sp_last;
        end
        // Owner dropping its request releases without a beat; otherwise the
        // burst ends on last or when the beat cap is reached.
        if (!beat || beat_last || (cnt + CNT_ONE) == CNT_MAX) begin
          state_nxt = IDLE;
          prio_nxt  = other_req(beat_owner);
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end

      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // FSM, priority pointer and beat counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      prio  <= REQ_BG;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      prio  <= prio_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Grants and the RAM port are combinational but forced quiet during reset.
  assign beat_ok  = beat & ~rst;
  assign bg_gnt   = beat_ok && (beat_owner == REQ_BG);
  assign sp_gnt   = beat_ok && (beat_owner == REQ_SP);
  assign ram_en   = beat_ok;
  assign ram_addr = !beat_ok               ? '0      :
                    (beat_owner == REQ_BG) ? bg_addr : sp_addr;

  vram_rsp_pipe #(
    .RD_LAT (RD_LAT)
  ) u_rsp_pipe (
    .clk         (clk),
    .rst         (rst),
    .issue       (beat_ok),
    .owner       (beat_owner),
    .valid       (rsp_valid),
    .valid_owner (rsp_owner)
  );

  // The RAM data bus fans out to both engines; rvalid says whose it is.
  assign bg_rvalid = rsp_valid && (rsp_owner == REQ_BG);
  assign sp_rvalid = rsp_valid && (rsp_owner == REQ_SP);
  assign bg_rdata  = rst ? '0 : ram_dout;
  assign sp_rdata  = rst ? '0 : ram_dout;

endmodule
